// File: rtl/chip8_pkg.sv
// Shared constants and FSM state type for the CHIP-8 unified memory.
package chip8_pkg;

    localparam logic [11:0] FONT_BASE = 12'h000;
    localparam int unsigned FONT_LEN  = 80;
    localparam logic [11:0] PROG_BASE = 12'h200;
    localparam int unsigned MEM_DEPTH = 4096;

    typedef enum logic [1:0] {
        INIT_FONT,
        WAIT_LOAD,
        LOAD,
        RUN
    } mem_state_t;

endpackage

// File: rtl/chip8_memory_if.sv
// CPU memory port and program loader stream grouped as one bus.
interface chip8_memory_if;

    logic        mem_read;
    logic        mem_write;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
    logic        load_ready;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        output load_valid, load_data, load_last,
        input  mem_rdata, load_ready
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        input  load_valid, load_data, load_last,
        output mem_rdata, load_ready
    );

endinterface

// File: rtl/chip8_font_rom.sv
// Combinational hex font: 16 glyphs of 5 bytes each, glyph d at index 5*d.
module chip8_font_rom (
    input  logic [6:0] index,
    output logic [7:0] data
);

    localparam logic [7:0] FONT [80] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,   // 0
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,   // 1
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,   // 2
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,   // 3
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,   // 4
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,   // 5
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,   // 6
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,   // 7
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,   // 8
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,   // 9
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,   // A
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,   // B
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,   // C
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,   // D
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,   // E
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80    // F
    };

    always_comb begin
        data = '0;
        if (index < 7'd80) data = FONT[index];
    end

endmodule

// File: rtl/chip8_memory.sv
// CHIP-8 4 KiB memory: font preload, streamed program load, then CPU service.
// Optional macro CHIP8_MEM_WRPROT_EN drops RUN writes below 0x200 and flags wr_err.
import chip8_pkg::*;

module chip8_memory (
    input  logic           clk,
    input  logic           reset_n,
    chip8_memory_if.slave  bus,
    output logic [11:0]    load_count,
    output logic           cpu_hold,
    output logic           wr_err
);

    logic [7:0]  mem [MEM_DEPTH];
    mem_state_t  state;
    logic [6:0]  font_idx;
    logic [7:0]  font_byte;
    logic        ready;
    logic        we;
    logic [11:0] waddr;
    logic [7:0]  wdata;
    logic [11:0] load_addr;
    logic        load_xfer;
    logic        load_end;
    logic        cpu_wr_ok;
    logic        unused_read;

    chip8_font_rom u_font (
        .index (font_idx),
        .data  (font_byte)
    );

    assign unused_read    = bus.mem_read;
    assign bus.load_ready = ready;
    assign load_xfer      = bus.load_valid && ready;
    assign load_addr      = PROG_BASE + load_count;
    assign load_end       = bus.load_last || (load_addr == 12'hFFF);

`ifdef CHIP8_MEM_WRPROT_EN
    assign cpu_wr_ok = (bus.mem_addr >= PROG_BASE);
`else
    assign cpu_wr_ok = 1'b1;
`endif

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        case (state)
            INIT_FONT: begin
                we    = 1'b1;
                waddr = FONT_BASE + {5'b0, font_idx};
                wdata = font_byte;
            end
            WAIT_LOAD, LOAD: begin
                we    = load_xfer;
                waddr = load_addr;
                wdata = bus.load_data;
            end
            RUN: begin
                we    = bus.mem_write && cpu_wr_ok;
                waddr = bus.mem_addr;
                wdata = bus.mem_wdata;
            end
            default: ;
        endcase
    end

    // Array is deliberately outside reset so loaded bytes survive a reset pulse.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign bus.mem_rdata = mem[bus.mem_addr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= INIT_FONT;
            font_idx   <= '0;
            load_count <= '0;
            ready      <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            case (state)
                INIT_FONT: begin
                    font_idx <= font_idx + 7'd1;
                    if (font_idx == 7'(FONT_LEN - 1)) begin
                        state <= WAIT_LOAD;
                        ready <= 1'b1;
                    end
                end
                WAIT_LOAD, LOAD: begin
                    if (load_xfer) begin
                        load_count <= load_count + 12'd1;
                        state      <= LOAD;
                        if (load_end) begin
                            state    <= RUN;
                            ready    <= 1'b0;
                            cpu_hold <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CHIP8_MEM_WRPROT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wr_err <= 1'b0;
        else if (state == RUN && bus.mem_write && !cpu_wr_ok)
            wr_err <= 1'b1;
    end
`else
    assign wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_chip8_memory.sv
// Randomized bench for chip8_memory against a per-cycle behavioural memory model.
module tb_chip8_memory;

`ifdef CHIP8_MEM_WRPROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] load_count;
    logic        cpu_hold;
    logic        wr_err;

    always #5 clk = ~clk;

    chip8_memory_if bus ();

    chip8_memory dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .load_count (load_count),
        .cpu_hold   (cpu_hold),
        .wr_err     (wr_err)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: phase 0 = font preload, 1 = accepting loader, 2 = run
    logic [7:0] font_tab [80] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0, 8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0, 8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10, 8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0, 8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0, 8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90, 8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0, 8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0, 8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };
    logic [7:0] m_mem   [4096];
    bit         m_known [4096];
    int         m_phase = 0;
    int         m_font  = 0;
    int         m_count = 0;
    int         m_addr;
    bit         m_ready = 1'b0;
    bit         m_hold  = 1'b1;
    bit         m_err   = 1'b0;

    // Compare current outputs, then advance the model by the edge that follows.
    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_load_ready", bus.load_ready, 0);
            check("rst_cpu_hold", cpu_hold, 1);
            check("rst_load_count", load_count, 0);
            check("rst_wr_err", wr_err, 0);
            m_phase = 0; m_font = 0; m_count = 0;
            m_ready = 1'b0; m_hold = 1'b1; m_err = 1'b0;
        end else begin
            check("load_ready", bus.load_ready, m_ready);
            check("cpu_hold", cpu_hold, m_hold);
            check("load_count", load_count, m_count);
            check("wr_err", wr_err, m_err);
            if (m_known[bus.mem_addr]) check("mem_rdata", bus.mem_rdata, m_mem[bus.mem_addr]);
            case (m_phase)
                0: begin
                    m_mem[m_font] = font_tab[m_font];
                    m_known[m_font] = 1'b1;
                    m_font++;
                    if (m_font == 80) begin m_phase = 1; m_ready = 1'b1; end
                end
                1: if (bus.load_valid) begin
                    m_addr = ('h200 + m_count) % 4096;
                    m_mem[m_addr] = bus.load_data;
                    m_known[m_addr] = 1'b1;
                    m_count++;
                    if (bus.load_last || m_addr == 'hFFF) begin
                        m_phase = 2; m_ready = 1'b0; m_hold = 1'b0;
                    end
                end
                default: if (bus.mem_write) begin
                    if (PROT && bus.mem_addr < 12'h200) m_err = 1'b1;
                    else begin
                        m_mem[bus.mem_addr] = bus.mem_wdata;
                        m_known[bus.mem_addr] = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_wdata = '0;
        bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_font(input int exp_cycles);
        int n = 0;
        while (!bus.load_ready && n < 200) begin tick(); n++; end
        check("font_cycles", n, exp_cycles);
    endtask

    task automatic send(input logic [7:0] d, input bit last, input bit gaps);
        int n = 0;
        if (gaps) begin
            bus.load_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        bus.load_valid = 1'b1; bus.load_data = d; bus.load_last = last;
        while (!bus.load_ready && n < 50) begin tick(); n++; end
        if (n == 50) check("send_timeout", 0, 1);
        tick();
        bus.load_valid = 1'b0; bus.load_last = 1'b0;
    endtask

    task automatic peek(input logic [11:0] a, input logic [7:0] exp, input string name);
        bus.mem_addr = a; bus.mem_write = 1'b0;
        @(negedge clk);
        check(name, bus.mem_rdata, exp);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        logic [7:0] first_b;
        logic [11:0] a;
        bus.mem_addr = '0;
        do_reset();
        wait_font(80);
        peek(12'h000, 8'hF0, "font_000");
        peek(12'h004, 8'hF0, "font_004");
        peek(12'h04B, 8'hF0, "font_04B");
        peek(12'h04F, 8'h80, "font_04F");
        check("hold_after_font", cpu_hold, 1);

        send(8'h12, 1'b0, 1'b1);
        send(8'h34, 1'b0, 1'b1);
        send(8'hA1, 1'b0, 1'b1);
        send(8'hFF, 1'b1, 1'b1);
        check("hold_fell_on_last", cpu_hold, 0);
        peek(12'h200, 8'h12, "prog_200");
        peek(12'h201, 8'h34, "prog_201");
        peek(12'h202, 8'hA1, "prog_202");
        peek(12'h203, 8'hFF, "prog_203");
        check("count_after_4", load_count, 4);
        check("ready_in_run", bus.load_ready, 0);

        bus.mem_addr = 12'h300; bus.mem_wdata = 8'h5A; bus.mem_write = 1'b1;
        tick();
        bus.mem_write = 1'b0;
        @(negedge clk); check("wr_300_5A", bus.mem_rdata, 8'h5A);
        tick();
        bus.mem_wdata = 8'h77; bus.mem_write = 1'b1;
        @(negedge clk); check("rw_same_old", bus.mem_rdata, 8'h5A);
        tick();
        bus.mem_write = 1'b0;
        @(negedge clk); check("rw_same_new", bus.mem_rdata, 8'h77);
        tick();

        bus.mem_addr = 12'h010; bus.mem_wdata = 8'hAA; bus.mem_write = 1'b1;
        tick();
        peek(12'h010, PROT ? 8'h10 : 8'hAA, "low_write_010");
        check("wr_err_low", wr_err, PROT ? 1 : 0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 2))
                0: a = 12'h300 + 12'($urandom_range(0, 15));
                1: a = 12'($urandom_range(0, 15));
                default: a = 12'h200 + 12'($urandom_range(0, 3));
            endcase
            bus.mem_addr = a;
            bus.mem_read = 1'($urandom_range(0, 1));
            bus.mem_write = ($urandom_range(0, 9) < 3);
            bus.mem_wdata = 8'($urandom);
            bus.load_valid = 1'($urandom_range(0, 1));
            tick();
        end
        idle_inputs();

        do_reset();
        wait_font(80);
        send(8'h11, 1'b0, 1'b1);
        send(8'h22, 1'b0, 1'b1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        bus.mem_addr = 12'h200;
        @(negedge clk);
        check("retained_200", bus.mem_rdata, 8'h11);
        check("count_cleared", load_count, 0);
        check("ready_cleared", bus.load_ready, 0);
        tick();
        wait_font(79);
        send(8'h33, 1'b1, 1'b1);
        peek(12'h200, 8'h33, "reload_200");
        peek(12'h201, 8'h22, "retained_201");

        do_reset();
        wait_font(80);
        first_b = 8'($urandom);
        b = first_b;
        send(b, 1'b0, 1'b0);
        for (int i = 1; i < 3584; i++) begin
            b = 8'($urandom);
            bus.load_valid = 1'b1; bus.load_data = b; bus.load_last = 1'b0;
            if (!bus.load_ready) check("stream_ready", 0, 1);
            tick();
        end
        bus.load_valid = 1'b0;
        check("full_hold", cpu_hold, 0);
        check("full_count", load_count, 3584);
        check("full_ready", bus.load_ready, 0);
        peek(12'hFFF, b, "full_FFF");
        peek(12'h200, first_b, "full_200");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
